// File: rtl/bank_pkg.sv
// ============================================================================
// Module      : bank_pkg
// Description : Shared widths, FSM states and grant encoding for the BIU
//               request queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bank_pkg;

  localparam int SET_WAY_W = 6;
  localparam int LINE_OFS  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_AW   = 2'd2
  } biu_q_state_e;

  typedef enum logic {
    GNT_AR = 1'b0,
    GNT_AW = 1'b1
  } biu_q_grant_e;

endpackage

`default_nettype wire

// File: rtl/bank_biu_req_fifo.sv
// ============================================================================
// Module      : bank_biu_req_fifo
// Description : Synchronous FIFO with registered head, no empty bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_biu_req_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) begin
        mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bank_biu_req_queue.sv
// ============================================================================
// Module      : bank_biu_req_queue
// Description : Registered AR/AW request queue between htu and biu with a
//               round-robin, request-locked channel arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_biu_req_queue
  import bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           htu_q_arvalid_i,
  output logic                           htu_q_arready_o,
  input  logic [ADDR_WIDTH-LINE_OFS-1:0] htu_q_araddr_i,
  input  logic [SET_WAY_W-1:0]           htu_q_ar_set_way_i,
  input  logic                           htu_q_awvalid_i,
  output logic                           htu_q_awready_o,
  input  logic [ADDR_WIDTH-LINE_OFS-1:0] htu_q_awaddr_i,
  input  logic [SET_WAY_W-1:0]           htu_q_aw_set_way_i,
  output logic                           q_biu_arvalid_o,
  input  logic                           q_biu_arready_i,
  output logic [ADDR_WIDTH-LINE_OFS-1:0] q_biu_araddr_o,
  output logic                           q_biu_awvalid_o,
  input  logic                           q_biu_awready_i,
  output logic [ADDR_WIDTH-LINE_OFS-1:0] q_biu_awaddr_o,
  output logic [SET_WAY_W-1:0]           q_biu_set_way_o,
  output logic                           q_idle_o
);

  localparam int LA_W  = ADDR_WIDTH - LINE_OFS;
  localparam int ENT_W = LA_W + SET_WAY_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  biu_q_state_e state_q, state_d;
  biu_q_grant_e last_grant_q, last_grant_d;

  logic             ar_full, ar_empty, ar_pop;
  logic             aw_full, aw_empty, aw_pop;
  logic [CNT_W-1:0] ar_count, aw_count;
  logic [ENT_W-1:0] ar_head, aw_head;

  bank_biu_req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_ar_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (htu_q_arvalid_i),
    .data_i  ({htu_q_araddr_i, htu_q_ar_set_way_i}),
    .full_o  (ar_full),
    .pop_i   (ar_pop),
    .empty_o (ar_empty),
    .count_o (ar_count),
    .head_o  (ar_head)
  );

  bank_biu_req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (htu_q_awvalid_i),
    .data_i  ({htu_q_awaddr_i, htu_q_aw_set_way_i}),
    .full_o  (aw_full),
    .pop_i   (aw_pop),
    .empty_o (aw_empty),
    .count_o (aw_count),
    .head_o  (aw_head)
  );

  assign htu_q_arready_o = ~ar_full;
  assign htu_q_awready_o = ~aw_full;

  assign q_biu_arvalid_o = (state_q == S_AR);
  assign q_biu_awvalid_o = (state_q == S_AW);
  assign q_biu_araddr_o  = ar_head[ENT_W-1:SET_WAY_W];
  assign q_biu_awaddr_o  = aw_head[ENT_W-1:SET_WAY_W];
  // Single shared set_way bus; channel is selected by the locked grant.
  assign q_biu_set_way_o = (state_q == S_AW) ? aw_head[SET_WAY_W-1:0]
                                             : ar_head[SET_WAY_W-1:0];
  assign q_idle_o        = ar_empty & aw_empty & (state_q == S_IDLE);

  assign ar_pop = (state_q == S_AR) & q_biu_arready_i;
  assign aw_pop = (state_q == S_AW) & q_biu_awready_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (!ar_empty && !aw_empty) begin
          state_d = (last_grant_q == GNT_AW) ? S_AR : S_AW;
        end else if (!ar_empty) begin
          state_d = S_AR;
        end else if (!aw_empty) begin
          state_d = S_AW;
        end
      end
      S_AR: begin
        if (q_biu_arready_i) begin
          last_grant_d = GNT_AR;
          // Counts exclude this cycle's push; new entries re-enter via S_IDLE.
          if (!aw_empty) begin
            state_d = S_AW;
          end else if (ar_count > CNT_W'(1)) begin
            state_d = S_AR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_AW: begin
        if (q_biu_awready_i) begin
          last_grant_d = GNT_AW;
          if (!ar_empty) begin
            state_d = S_AR;
          end else if (aw_count > CNT_W'(1)) begin
            state_d = S_AW;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_AW;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/bank_biu_req_queue.md
Name: bank_biu_req_queue

Overview:
Request queue between the hit/tag unit (htu) and the bank bus interface unit (biu); it closes the timing path from htu to the AXI3 AR/AW channels.
- Buffers read-refill requests and writeback requests in two separate FIFOs.
- Drives one request to biu per handshake. AR and AW share a single set_way bus to biu, so the two channels are never offered at the same time.
- Picks between AR and AW round-robin, and locks the choice while the request waits for ready.

Parameters:
ADDR_WIDTH, 32, byte address width; only line address [ADDR_WIDTH-1:5] is carried
DEPTH, 4, entries per FIFO; power of two, >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
htu_q_arvalid_i  in  1  read-refill request valid
htu_q_arready_o  out  1  AR FIFO not full
htu_q_araddr_i  in  ADDR_WIDTH-5  line address [ADDR_WIDTH-1:5]
htu_q_ar_set_way_i  in  6  set/way tag for refill
htu_q_awvalid_i  in  1  writeback request valid
htu_q_awready_o  out  1  AW FIFO not full
htu_q_awaddr_i  in  ADDR_WIDTH-5  line address [ADDR_WIDTH-1:5]
htu_q_aw_set_way_i  in  6  set/way tag for writeback
q_biu_arvalid_o  out  1  AR request to biu
q_biu_arready_i  in  1  biu accepts AR
q_biu_araddr_o  out  ADDR_WIDTH-5  AR FIFO head address
q_biu_awvalid_o  out  1  AW request to biu
q_biu_awready_i  in  1  biu accepts AW
q_biu_awaddr_o  out  ADDR_WIDTH-5  AW FIFO head address
q_biu_set_way_o  out  6  AW head set_way in S_AW, otherwise AR head set_way
q_idle_o  out  1  both FIFOs empty and FSM in S_IDLE

Behaviour:
Reset values:
- all FIFO entries and pointers 0; FSM in S_IDLE; last_grant = AW, so the first contest goes to AR.
- arvalid_o = 0, awvalid_o = 0, addresses = 0, set_way = 0, arready_o = 1, awready_o = 1, q_idle_o = 1.

Enqueue (each FIFO):
- Push on valid_i & ready_o.
- ready_o = !full, from registered state only, with no dependence on a same-cycle pop. A full FIFO accepts no push even when a pop happens that cycle.
- No bypass when empty. A pushed entry is visible at the head on the next cycle.

FSM (registered), states S_IDLE, S_AR, S_AW:
- arvalid_o = (state == S_AR); awvalid_o = (state == S_AW).
- S_IDLE:
  - Only AR non-empty -> S_AR; only AW non-empty -> S_AW.
  - Both non-empty -> the opposite of last_grant.
  - Neither -> stay in S_IDLE.
- S_AR:
  - Hold while !arready_i. Valid, address and set_way stay stable (AXI rule).
  - On handshake: pop AR, set last_grant = AR, then:
    - AW non-empty -> S_AW;
    - else AR count > 1 -> S_AR;
    - else -> S_IDLE.
- S_AW: symmetric to S_AR.
- Occupancy checks in S_AR/S_AW use the count before this cycle's push. An entry pushed in the handshake cycle is picked up one cycle later, through S_IDLE.

Latency and throughput:
- Empty queue, push at cycle N -> valid at cycle N+2.
- Back-to-back handshakes with no bubble while entries remain.

Simultaneous push and pop on the same FIFO: count unchanged, pointers both advance.

Wrap-around: pointers are log2(DEPTH)+1 bits; full = MSBs differ and low bits equal; empty = pointers equal.

Reset asserted mid-operation:
- All queued requests are discarded and outputs return to reset values immediately (asynchronous).
- Any in-flight valid drops. Preventing this is the system's responsibility.

q_idle_o is combinational from registered state.

Decomposition:
- Package bank_pkg:
  - SET_WAY_W = 6, LINE_OFS = 5;
  - enum biu_q_state_e {S_IDLE, S_AR, S_AW};
  - grant type {GNT_AR, GNT_AW}.
- Sub-module bank_biu_req_fifo: generic sync FIFO with parameters WIDTH and DEPTH, ports push/full/pop/empty/count/head. Instantiated twice, with WIDTH = ADDR_WIDTH-5+6.

Test Plan:
- Single read: AR push addr 0x0123456, set_way 0x2A at cycle 0, arready tied 1 -> arvalid high in cycle 2 only, araddr = 0x0123456, set_way = 0x2A, awvalid never high.
- Contest: AR (set_way 0x01) and AW (set_way 0x3F) pushed in the same cycle after reset -> AR granted first (set_way 0x01), AW handshake in the very next cycle (set_way 0x3F); the two valids are never high together.
- Backpressure: arready held 0 for 5 cycles with AW queued -> arvalid, araddr and set_way stable all 5 cycles; awvalid stays 0 until the AR handshake.
- Full: 4 AR pushes with arready 0 -> arready_o = 0 after the 4th; a 5th push is ignored. Release arready -> 4 handshakes in order with no bubble.
- Round-robin: 3 AR and 3 AW queued, ready tied 1 -> grants alternate AR, AW, AR, AW, AR, AW; q_idle_o = 1 afterwards.
- Reset mid-operation: 2 entries queued and arvalid high, rst_i driven low -> arvalid 0 immediately; after release both readies are 1, q_idle_o = 1, and no stale request is ever issued.
